// File: rtl/prirv32_pkg.sv
// prirv32_pkg: shared constants and types for the priRV32 front end.
//   XLEN        - architectural register / address width
//   NOP         - canonical ADDI x0,x0,0 encoding shown on the fetch output out of reset
//   ifu_state_t - fetch unit FSM encoding (BOOT, RUN, DRAIN)
package prirv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/prirv32_sync_fifo.sv
// prirv32_sync_fifo: single-clock FIFO with flush and an occupancy count.
//   clk, rst   - clock, synchronous active-high reset
//   flush      - empties the FIFO; a push or pop in the same cycle is ignored
//   push       - write push_data (accepted when not full, or when a pop frees a slot)
//   pop        - drop the head entry (ignored when empty)
//   head       - current head entry (combinational read)
//   count      - number of valid entries
//   full/empty - occupancy flags
module prirv32_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so a non power-of-two depth still indexes correctly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/prirv32_fetch_unit.sv
// prirv32_fetch_unit: instruction fetch stage feeding the priRV32 decoder.
//   clk_in, rst_in        - clock, synchronous active-high reset
//   imem_req_o/addr_o     - word fetch request and its address
//   imem_gnt_i            - request accepted this cycle
//   imem_rvalid_i/rdata_i - in-order response, earliest one cycle after grant
//   redirect_i/pc_i       - branch/jump/trap redirect from execute (highest priority)
//   ifu_valid_o/ready_i   - valid/ready handshake to the decoder
//   ifu_pc_o/instr_o      - {pc, instr} of the buffer head; hold last values when empty
//   ifu_fault_o           - only with PRIRV32_IFU_MISALIGN_CHECK_EN: one-cycle pulse on
//                           a redirect whose target is not word aligned
//
// Handshakes: a request transfers on a cycle with imem_req_o && imem_gnt_i; an
// ungranted request may be withdrawn. An instruction transfers to the decoder on
// a cycle with ifu_valid_o && ifu_ready_i; while valid && !ready the outputs hold.
//
// Build option: define PRIRV32_IFU_MISALIGN_CHECK_EN to add misaligned-redirect
// detection; otherwise the low two target bits are silently cleared.
module prirv32_fetch_unit
    import prirv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            ifu_valid_o,
    input  logic            ifu_ready_i,
    output logic [XLEN-1:0] ifu_pc_o,
`ifdef PRIRV32_IFU_MISALIGN_CHECK_EN
    output logic            ifu_fault_o,
`endif
    output logic [XLEN-1:0] ifu_instr_o
);

    localparam int TW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(FIFO_DEPTH + 1);

    ifu_state_t      state;
    ifu_state_t      state_next;
    logic [TW-1:0]   discard;
    logic [TW-1:0]   discard_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] last_instr;

    logic [XLEN-1:0]   tag_head;
    logic [TW-1:0]     tag_count;
    logic              tag_full;
    logic              tag_empty;
    logic [2*XLEN-1:0] ibuf_head;
    logic [BW-1:0]     ibuf_count;
    logic              ibuf_full;
    logic              ibuf_empty;

    logic tag_push;
    logic rsp_live;
    logic ibuf_pop;
    logic misaligned;
    logic fetch_en;
    logic pc_load;

`ifdef PRIRV32_IFU_MISALIGN_CHECK_EN
    logic fault_q;

    assign misaligned  = (redirect_pc_i[1:0] != 2'b00);
    assign ifu_fault_o = fault_q;

    // A misaligned redirect parks fetch until a well-formed redirect arrives.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fault_q  <= 1'b0;
            fetch_en <= 1'b1;
        end else begin
            fault_q <= redirect_i && misaligned;
            if (redirect_i) begin
                fetch_en <= !misaligned;
            end
        end
    end
`else
    logic unused_low_bits;

    assign misaligned      = 1'b0;
    assign fetch_en        = 1'b1;
    assign unused_low_bits = ^redirect_pc_i[1:0];
`endif

    assign pc_load = redirect_i && !misaligned;

    // Credit check counts both in-flight words and buffered words, so every
    // response that comes back is guaranteed a buffer slot.
    assign imem_req_o  = (state == ST_RUN) && fetch_en && !redirect_i && !tag_full &&
                         ((int'(tag_count) + int'(ibuf_count)) < FIFO_DEPTH);
    assign imem_addr_o = fetch_pc;
    assign tag_push    = imem_req_o && imem_gnt_i;

    // Only responses to requests issued since the last redirect are kept.
    assign rsp_live = imem_rvalid_i && (state == ST_RUN) && !tag_empty;
    assign ibuf_pop = ifu_valid_o && ifu_ready_i;

    assign ifu_valid_o = !ibuf_empty;
    assign ifu_pc_o    = ibuf_empty ? last_pc    : ibuf_head[2*XLEN-1:XLEN];
    assign ifu_instr_o = ibuf_empty ? last_instr : ibuf_head[XLEN-1:0];

    prirv32_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk       (clk_in),
        .rst       (rst_in),
        .flush     (redirect_i),
        .push      (tag_push),
        .push_data (fetch_pc),
        .pop       (rsp_live),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    prirv32_sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk       (clk_in),
        .rst       (rst_in),
        .flush     (redirect_i),
        .push      (rsp_live),
        .push_data ({tag_head, imem_rdata_i}),
        .pop       (ibuf_pop),
        .head      (ibuf_head),
        .count     (ibuf_count),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_BOOT;
            discard <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    always_comb begin
        state_next   = state;
        discard_next = discard;
        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    // A response arriving in the redirect cycle is already accounted for.
                    discard_next = tag_count - TW'(rsp_live);
                    state_next   = (discard_next != '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid_i && discard != '0) begin
                    discard_next = discard - TW'(1);
                    if (discard_next == '0) begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: begin
                state_next   = ST_BOOT;
                discard_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc <= RESET_PC;
        end else if (pc_load) begin
            fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (tag_push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Shadow of the head so the decoder side keeps its last values when empty.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_pc    <= '0;
            last_instr <= NOP;
        end else if (!ibuf_empty) begin
            last_pc    <= ibuf_head[2*XLEN-1:XLEN];
            last_instr <= ibuf_head[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && state == ST_RUN) begin
            assert (!(imem_rvalid_i && tag_empty));
            assert (!(rsp_live && ibuf_full && !ibuf_pop));
        end
    end

endmodule

// File: doc/prirv32_fetch_unit.md
Name: prirv32_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the priRV32 decoder.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PC in a small FIFO and presents {pc, instr} to the decoder over valid/ready.
- Accepts redirects (branch, jump, trap) from execute, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum granted-but-unreturned requests.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, synchronous, active-high
- imem_req_o  output  1  fetch request
- imem_addr_o  output  32  word-aligned fetch address
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response data valid; in order; earliest 1 cycle after gnt
- imem_rdata_i  input  32  instruction word
- redirect_i  input  1  redirect fetch
- redirect_pc_i  input  32  redirect target
- ifu_valid_o  output  1  instruction valid to decoder
- ifu_ready_i  input  1  decoder accepts
- ifu_pc_o  output  32  PC of ifu_instr_o
- ifu_instr_o  output  32  instruction word to decoder (feeds pc_data_i)

Behaviour:
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, ifu_valid_o=0, ifu_pc_o=0, ifu_instr_o=32'h0000_0013 (NOP). FIFO empty, outstanding=0, discard=0, state=BOOT.
- Reset mid-operation: all state returns to reset values at the next edge. Responses still in flight are never pushed.
- FSM states:
  - BOOT: exactly 1 cycle, no request, then RUN.
  - RUN: normal fetch.
  - DRAIN: discard>0. No requests; each rvalid is dropped and decrements discard. Go to RUN when discard reaches 0.
- Request rule in RUN: imem_req_o=1 when outstanding<MAX_OUTSTANDING, outstanding+fifo_count<FIFO_DEPTH, and redirect_i=0.
- On req&&gnt: fetch_pc+=4 (mod 2^32, wraps 0xFFFF_FFFC→0); that PC is pushed into an in-order PC tag queue.
- Memory tolerates withdrawal of an ungranted request.
- Response: rvalid pushes {tag_pc, rdata} into the FIFO. Credit accounting guarantees no overflow.
- Latency: gnt at cycle t, rvalid at t+1 → ifu_valid_o at t+2 (no bypass).
- Output: FIFO head drives ifu_*. Pop on valid&&ready. Outputs hold stable while valid&&!ready.
- When empty: ifu_valid_o=0; pc and instr hold their last values.
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}.
  - FIFO flushed; a same-cycle pop and push are ignored.
  - discard <= outstanding − (rvalid this cycle ? 1 : 0); the state goes to DRAIN if that is nonzero, else RUN.
  - imem_req_o=0 in the redirect cycle.
- Redirect during DRAIN reloads fetch_pc only; discard continues its count.
- Redirect during BOOT reloads fetch_pc; BOOT still completes.
- Simultaneous gnt and rvalid: outstanding unchanged.
- rvalid with outstanding=0 is a protocol error; it is ignored (assertion in sim).

Optional Feature:
- Macro: PRIRV32_IFU_MISALIGN_CHECK_EN.
- Defined:
  - Adds output ifu_fault_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 pulses ifu_fault_o for 1 cycle and does not update fetch_pc.
  - Flush and discard still occur; the state goes to DRAIN or RUN by discard, and no requests issue until the next valid redirect.
- Undefined: no port; low bits are silently cleared.

Decomposition:
- Package prirv32_pkg holds:
  - NOP constant 32'h0000_0013
  - FSM state encoding (BOOT, RUN, DRAIN)
  - XLEN=32
- One sub-module: prirv32_sync_fifo (parameterised width/depth, push/pop/flush, count, full/empty), instanced twice:
  - PC tag queue, depth MAX_OUTSTANDING.
  - Instruction buffer, width 64, depth FIFO_DEPTH.

Test Plan:
- Reset release, memory grants every cycle, rvalid 1 cycle later: addresses 0x0, 0x4, 0x8…; first ifu_valid_o at cycle 3 after BOOT with pc=0x0; one instruction per cycle thereafter with ready=1.
- ifu_ready_i=0 for 10 cycles: imem_req_o drops once outstanding+count=2; ifu_pc_o/instr stable. Release ready → sequence resumes with no gaps or duplicates.
- Two requests outstanding, redirect_i with target 0x100: both responses dropped (DRAIN 2 cycles), next request addr 0x100, first delivered pc=0x100.
- Redirect in the same cycle as rvalid with outstanding=1: discard=0, no DRAIN, req to target next cycle.
- Fetch PC at 0xFFFF_FFFC: next address 0x0000_0000.
- With PRIRV32_IFU_MISALIGN_CHECK_EN, redirect to 0x102: ifu_fault_o=1 for one cycle, no requests until redirect to 0x200, which fetches normally.
